// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants and helpers for the VGA timing generator.
//   Each axis (horizontal in pixels, vertical in lines) is described by the
//   same four-segment layout: active, front porch, sync, back porch.
//   Two standard modes are provided: 640x480@60 (the generator defaults) and
//   800x600@60.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

  // One axis worth of timing, in pixels (horizontal) or lines (vertical).
  typedef struct packed {
    int act;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  // 640x480@60, 25.175 MHz pixel clock.
  localparam axis_timing_t VGA640_H = '{act: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_timing_t VGA640_V = '{act: 480, fp: 10, sync: 2,  bp: 33};

  // 800x600@60, 40 MHz pixel clock (positive sync polarity in the standard).
  localparam axis_timing_t SVGA800_H = '{act: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_timing_t SVGA800_V = '{act: 600, fp: 1,  sync: 4,   bp: 23};

  // Total length of one axis period.
  function automatic int axis_total(input int act, input int fp,
                                    input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
//   Wrap counter for one display axis. Counts 0..TOTAL-1 and wraps to 0.
//   It advances only when both ce and cin are high, so chaining cout of the
//   horizontal counter into cin of the vertical one gives a raster counter.
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, loads RST_VAL
//   ce        in   clock enable (pixel clock enable)
//   cin       in   carry in; counter steps when ce && cin
//   cnt       out  registered count
//   cnt_next  out  value cnt takes on the next clock edge
//   cout      out  carry out: cin high while cnt is at TOTAL-1 (wrap pending)
// ----------------------------------------------------------------------------
module vga_axis_counter #(
  parameter int CW      = 11,
  parameter int TOTAL   = 800,
  parameter int RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          cin,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next,
  output logic          cout
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] RST  = CW'(RST_VAL);

  logic at_last;

  assign at_last = (cnt == LAST);
  assign cout    = cin && at_last;

  always_comb begin
    // NOTE: default assignment first so every path assigns cnt_next and no
    // latch is inferred when the step condition is false.
    cnt_next = cnt;
    if (ce && cin) begin
      cnt_next = at_last ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      cnt <= RST;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for a VGA-style display. A horizontal/vertical
//   counter pair walks the frame one position per ce cycle; a second,
//   independent pair runs FETCH_LEAD positions ahead so a pixel source with
//   a fixed pipeline delay can be addressed early.
//
//   All decoded outputs are registered but computed from the counters'
//   next-state values, so they describe the position held in h/v on the same
//   cycle (no extra latency). On ce=0 cycles everything holds and the
//   strobes drop.
//
// Ports
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   ce            in   pixel clock enable
//   x, y          out  current position (blanking included)
//   active        out  current position is inside the visible area
//   hsync, vsync  out  sync pulses, level during pulse = HS_POL / VS_POL
//   line_start    out  one ce cycle when a new line begins (h = 0)
//   frame_start   out  one ce cycle when a new frame begins (h = 0, v = 0)
//   fetch_x/y     out  position FETCH_LEAD steps ahead of x/y
//   fetch_active  out  visibility of the fetch position
// ----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT      = VGA640_H.act,
  parameter int H_FP       = VGA640_H.fp,
  parameter int H_SYNC     = VGA640_H.sync,
  parameter int H_BP       = VGA640_H.bp,
  parameter int V_ACT      = VGA640_V.act,
  parameter int V_FP       = VGA640_V.fp,
  parameter int V_SYNC     = VGA640_V.sync,
  parameter int V_BP       = VGA640_V.bp,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FETCH_LEAD = 2,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_active
);

  localparam int H_TOTAL = axis_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACT, V_FP, V_SYNC, V_BP);
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // ---------------------------------------------------------------------------
  localparam bit TIMING_OK = (H_ACT >= 1) && (H_FP >= 1) && (H_SYNC >= 1) &&
                             (H_BP >= 1) && (V_ACT >= 1) && (V_FP >= 1) &&
                             (V_SYNC >= 1) && (V_BP >= 1);
  localparam bit LEAD_OK   = (FETCH_LEAD >= 0) &&
                             (FETCH_LEAD <= H_FP + H_SYNC + H_BP);
  localparam bit CW_OK     = (CW >= 1) && (CW <= 30) && (MAX_TOTAL <= (1 << CW));

  if (!TIMING_OK) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
  end
  if (!LEAD_OK) begin : g_bad_lead
    $fatal(1, "vga_timing_gen: FETCH_LEAD must be in 0..H_FP+H_SYNC+H_BP");
  end
  if (!CW_OK) begin : g_bad_cw
    $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  // ---------------------------------------------------------------------------
  // Decode constants
  // ---------------------------------------------------------------------------
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACT + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACT + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACT + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACT + V_FP + V_SYNC);

  // Fetch counters reset to the position FETCH_LEAD steps after (0,0). The
  // lead never exceeds one line, but the general form keeps this honest.
  localparam int F_H0 = FETCH_LEAD % H_TOTAL;
  localparam int F_V0 = (FETCH_LEAD / H_TOTAL) % V_TOTAL;
  localparam bit F_ACT0 = (F_H0 < H_ACT) && (F_V0 < V_ACT);

  // Half-open window test [lo, hi).
  function automatic logic in_win(input logic [CW-1:0] p,
                                  input logic [CW-1:0] lo,
                                  input logic [CW-1:0] hi);
    return (p >= lo) && (p < hi);
  endfunction

  // ---------------------------------------------------------------------------
  // Display counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] h_next, v_next;
  logic          h_cout, v_cout;

  vga_axis_counter #(.CW(CW), .TOTAL(H_TOTAL), .RST_VAL(0)) u_h_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .cin      (1'b1),
    .cnt      (x),
    .cnt_next (h_next),
    .cout     (h_cout)
  );

  vga_axis_counter #(.CW(CW), .TOTAL(V_TOTAL), .RST_VAL(0)) u_v_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .cin      (h_cout),
    .cnt      (y),
    .cnt_next (v_next),
    .cout     (v_cout)
  );

  // ---------------------------------------------------------------------------
  // Fetch counters (independent pair, same wrap behaviour)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] fh_next, fv_next;
  logic          fh_cout, fv_cout;
  logic          unused_fetch_carry;

  vga_axis_counter #(.CW(CW), .TOTAL(H_TOTAL), .RST_VAL(F_H0)) u_fh_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .cin      (1'b1),
    .cnt      (fetch_x),
    .cnt_next (fh_next),
    .cout     (fh_cout)
  );

  vga_axis_counter #(.CW(CW), .TOTAL(V_TOTAL), .RST_VAL(F_V0)) u_fv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .cin      (fh_cout),
    .cnt      (fetch_y),
    .cnt_next (fv_next),
    .cout     (fv_cout)
  );

  // The fetch frame wrap has no consumer; no fetch-side frame strobe exists.
  assign unused_fetch_carry = fv_cout;

  // ---------------------------------------------------------------------------
  // Registered decode from next-state positions
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= 1'b1;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      fetch_active <= F_ACT0;
    end else begin
      active       <= (h_next < H_ACT_C) && (v_next < V_ACT_C);
      hsync        <= in_win(h_next, HS_BEG, HS_END) ? HS_POL : ~HS_POL;
      vsync        <= in_win(v_next, VS_BEG, VS_END) ? VS_POL : ~VS_POL;
      // A carry out of the last column means the counters land on h=0 this
      // edge; gating with ce drops the strobes on hold cycles.
      line_start   <= ce && h_cout;
      frame_start  <= ce && v_cout;
      fetch_active <= (fh_next < H_ACT_C) && (fv_next < V_ACT_C);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Four generator instances share clk/ce/rst_n:
//     0 "A": small mode, HS active-low, VS active-high, FETCH_LEAD=3
//     1 "B": small mode, HS active-high, VS active-low, FETCH_LEAD=0
//     2 "D": all defaults (640x480)
//     3 "S": 800x600 constants, HS/VS active-high
//   The reference model only counts ce steps since reset; each expected
//   position is that step count taken modulo the line/frame lengths.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    bit hp; bit vp;
    int lead;
  } tim_t;

  localparam tim_t TA = '{ha: 8, hf: 2, hs: 3, hb: 2, va: 5, vf: 1, vs: 2, vb: 1,
                          hp: 1'b0, vp: 1'b1, lead: 3};
  localparam tim_t TB = '{ha: 6, hf: 1, hs: 2, hb: 1, va: 4, vf: 1, vs: 1, vb: 2,
                          hp: 1'b1, vp: 1'b0, lead: 0};
  localparam tim_t TD = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
                          hp: 1'b0, vp: 1'b0, lead: 2};
  localparam tim_t TS = '{ha: 800, hf: 40, hs: 128, hb: 88, va: 600, vf: 1, vs: 4, vb: 23,
                          hp: 1'b1, vp: 1'b1, lead: 2};

  localparam int A_FRAME = (8 + 2 + 3 + 2) * (5 + 1 + 2 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic [10:0] x [4];
  logic [10:0] y [4];
  logic [10:0] fx [4];
  logic [10:0] fy [4];
  logic        act [4];
  logic        hs [4];
  logic        vs [4];
  logic        ls [4];
  logic        fs [4];
  logic        fa [4];

  int    vectors = 0;
  int    miscompares = 0;
  longint n = 0;       // ce steps taken since reset release
  bit    stepped = 1'b0;
  int    cyc = 0;
  int    fs_cyc [$];
  string nm [4] = '{"A", "B", "D", "S"};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACT(TA.ha), .H_FP(TA.hf), .H_SYNC(TA.hs), .H_BP(TA.hb),
    .V_ACT(TA.va), .V_FP(TA.vf), .V_SYNC(TA.vs), .V_BP(TA.vb),
    .HS_POL(TA.hp), .VS_POL(TA.vp), .FETCH_LEAD(TA.lead), .CW(11)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x[0]), .y(y[0]), .active(act[0]),
    .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0]),
    .fetch_x(fx[0]), .fetch_y(fy[0]), .fetch_active(fa[0])
  );

  vga_timing_gen #(
    .H_ACT(TB.ha), .H_FP(TB.hf), .H_SYNC(TB.hs), .H_BP(TB.hb),
    .V_ACT(TB.va), .V_FP(TB.vf), .V_SYNC(TB.vs), .V_BP(TB.vb),
    .HS_POL(TB.hp), .VS_POL(TB.vp), .FETCH_LEAD(TB.lead), .CW(11)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x[1]), .y(y[1]), .active(act[1]),
    .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1]),
    .fetch_x(fx[1]), .fetch_y(fy[1]), .fetch_active(fa[1])
  );

  vga_timing_gen u_d (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x[2]), .y(y[2]), .active(act[2]),
    .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2]),
    .fetch_x(fx[2]), .fetch_y(fy[2]), .fetch_active(fa[2])
  );

  vga_timing_gen #(
    .H_ACT(SVGA800_H.act), .H_FP(SVGA800_H.fp), .H_SYNC(SVGA800_H.sync), .H_BP(SVGA800_H.bp),
    .V_ACT(SVGA800_V.act), .V_FP(SVGA800_V.fp), .V_SYNC(SVGA800_V.sync), .V_BP(SVGA800_V.bp),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x[3]), .y(y[3]), .active(act[3]),
    .hsync(hs[3]), .vsync(vs[3]), .line_start(ls[3]), .frame_start(fs[3]),
    .fetch_x(fx[3]), .fetch_y(fy[3]), .fetch_active(fa[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare one instance against the position reached after m steps.
  task automatic check_dut(input int k, input tim_t t, input longint m, input bit st);
    longint ht, vt, fm;
    int eh, ev, efh, efv;
    bit e_act, e_hs, e_vs, e_ls, e_fs, e_fa;
    ht  = longint'(t.ha + t.hf + t.hs + t.hb);
    vt  = longint'(t.va + t.vf + t.vs + t.vb);
    eh  = int'(m % ht);
    ev  = int'((m / ht) % vt);
    fm  = m + longint'(t.lead);
    efh = int'(fm % ht);
    efv = int'((fm / ht) % vt);
    e_act = (eh < t.ha) && (ev < t.va);
    e_hs  = (eh >= t.ha + t.hf && eh < t.ha + t.hf + t.hs) ? t.hp : ~t.hp;
    e_vs  = (ev >= t.va + t.vf && ev < t.va + t.vf + t.vs) ? t.vp : ~t.vp;
    e_ls  = st && (eh == 0);
    e_fs  = e_ls && (ev == 0);
    e_fa  = (efh < t.ha) && (efv < t.va);
    check({nm[k], ".x"},            32'(x[k]),   32'(eh));
    check({nm[k], ".y"},            32'(y[k]),   32'(ev));
    check({nm[k], ".active"},       32'(act[k]), 32'(e_act));
    check({nm[k], ".hsync"},        32'(hs[k]),  32'(e_hs));
    check({nm[k], ".vsync"},        32'(vs[k]),  32'(e_vs));
    check({nm[k], ".line_start"},   32'(ls[k]),  32'(e_ls));
    check({nm[k], ".frame_start"},  32'(fs[k]),  32'(e_fs));
    check({nm[k], ".fetch_x"},      32'(fx[k]),  32'(efh));
    check({nm[k], ".fetch_y"},      32'(fy[k]),  32'(efv));
    check({nm[k], ".fetch_active"}, 32'(fa[k]),  32'(e_fa));
  endtask

  task automatic check_all();
    check_dut(0, TA, n, stepped);
    check_dut(1, TB, n, stepped);
    check_dut(2, TD, n, stepped);
    check_dut(3, TS, n, stepped);
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare 1 time unit later.
  task automatic step(input bit ce_v, input bit rst_v);
    @(negedge clk);
    ce = ce_v;
    rst_n = rst_v;
    @(posedge clk);
    if (rst_n && ce) begin
      n++;
      stepped = 1'b1;
    end else begin
      stepped = 1'b0;
    end
    #1;
    cyc++;
    check_all();
    if (fs[0]) fs_cyc.push_back(cyc);
  endtask

  // Assert reset between clock edges and confirm it takes effect at once.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    n = 0;
    stepped = 1'b0;
    #1;
    check_all();
    repeat (hold) step(1'b1, 1'b0);
  endtask

  initial begin
    int k;
    bit got;

    // Reset state, including loaded fetch counters.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Continuous ce: two full frames of instance A.
    fs_cyc.delete();
    repeat (2 * A_FRAME + 5) step(1'b1, 1'b1);
    check("A.fs_count_ce1", 32'(fs_cyc.size()), 32'd2);
    if (fs_cyc.size() >= 2) check("A.frame_period_ce1", 32'(fs_cyc[1] - fs_cyc[0]), 32'(A_FRAME));

    // 50% duty ce: period doubles, outputs hold on ce=0 cycles.
    fs_cyc.delete();
    for (int i = 0; i < 4 * A_FRAME; i++) step(i[0] == 1'b0, 1'b1);
    check("A.fs_count_ce50", 32'(fs_cyc.size()), 32'd2);
    if (fs_cyc.size() >= 2) check("A.frame_period_ce50", 32'(fs_cyc[1] - fs_cyc[0]), 32'(2 * A_FRAME));

    // Random ce.
    for (int i = 0; i < 700; i++) step($urandom_range(0, 3) != 0, 1'b1);

    // Mid-frame async reset, held 3 cycles, then count to the next frame.
    async_reset(3);
    k = 0;
    got = 1'b0;
    while (!got && k < A_FRAME + 20) begin
      step(1'b1, 1'b1);
      k++;
      got = fs[0];
    end
    check("A.ce_steps_to_frame_after_reset", 32'(k), 32'(A_FRAME));

    // More random ce with an occasional short reset.
    for (int i = 0; i < 200; i++) begin
      if (i == 120) async_reset(1 + int'($urandom_range(0, 2)));
      step($urandom_range(0, 1) != 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
